// File: rtl/tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tile_scheduler
// Function : Walks the (n, k) tile loop of a matrix-multiply job, driving the
//            weight FIFO and systolic control unit one tile at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tile_scheduler #(
    parameter int ACC_ADDR_W = 7,
    parameter int TILE_ROWS  = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [CNT_W-1:0]      job_k_tiles_i,
    input  logic [CNT_W-1:0]      job_n_tiles_i,
    input  logic [ACC_ADDR_W-1:0] job_acc_base_i,
    input  logic                  abort_i,
    output logic                  wfifo_req_o,
    input  logic                  wfifo_tile_rdy_i,
    output logic                  cu_instruction_o,
    input  logic                  cu_done_i,
    output logic [ACC_ADDR_W-1:0] cu_acc_start_addr_o,
    output logic                  acc_accumulate_o,
    output logic [CNT_W-1:0]      tile_k_idx_o,
    output logic [CNT_W-1:0]      tile_n_idx_o,
    output logic                  busy_o,
    output logic                  job_done_o,
    output logic                  err_o
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH_W   = 3'd1;
    localparam logic [2:0] c_ISSUE     = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ADVANCE   = 3'd4;
    localparam logic [2:0] c_FINISH    = 3'd5;

    localparam logic [ACC_ADDR_W-1:0] c_ROW_STRIDE = ACC_ADDR_W'(TILE_ROWS);
    localparam logic [CNT_W-1:0]      c_ONE        = CNT_W'(1);

    logic [2:0]            state_q,   state_d;
    logic [CNT_W-1:0]      k_q,       k_d;
    logic [CNT_W-1:0]      n_q,       n_d;
    logic [CNT_W-1:0]      k_tiles_q, k_tiles_d;
    logic [CNT_W-1:0]      n_tiles_q, n_tiles_d;
    // Start row of the current output tile: base + n*TILE_ROWS, wrapping.
    logic [ACC_ADDR_W-1:0] row_q,     row_d;
    logic                  abort_q,   abort_d;
    logic                  err_q,     err_d;

    logic                  job_ready_q;
    logic                  busy_q;
    logic                  wfifo_req_q;
    logic                  cu_instr_q;
    logic                  job_done_q;
    logic [ACC_ADDR_W-1:0] addr_q;
    logic                  accum_q;

    logic w_accept;
    logic w_abort_seen;
    logic w_last_k;
    logic w_last_n;
    logic w_issue;
    logic w_abort_window;

    assign w_accept       = (state_q == c_IDLE) && job_valid_i && job_ready_q;
    assign w_abort_seen   = abort_q || abort_i;
    assign w_last_k       = (k_q == (k_tiles_q - c_ONE));
    assign w_last_n       = (n_q == (n_tiles_q - c_ONE));
    assign w_issue        = (state_q == c_FETCH_W) && (state_d == c_ISSUE);
    assign w_abort_window = (state_q != c_IDLE) && (state_q != c_FINISH);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        k_tiles_d = k_tiles_q;
        n_tiles_d = n_tiles_q;
        row_d     = row_q;
        abort_d   = abort_q;
        err_d     = err_q;

        if (w_abort_window && abort_i) begin
            abort_d = 1'b1;
            err_d   = 1'b1;
        end

        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    k_tiles_d = job_k_tiles_i;
                    n_tiles_d = job_n_tiles_i;
                    row_d     = job_acc_base_i;
                    k_d       = '0;
                    n_d       = '0;
                    abort_d   = 1'b0;
                    if ((job_k_tiles_i == '0) || (job_n_tiles_i == '0)) begin
                        err_d   = 1'b1;
                        state_d = c_FINISH;
                    end else begin
                        err_d   = 1'b0;
                        state_d = c_FETCH_W;
                    end
                end
            end
            c_FETCH_W: begin
                // Nothing is in flight yet, so an abort here ends the job at once.
                if (w_abort_seen) begin
                    state_d = c_FINISH;
                end else if (wfifo_tile_rdy_i) begin
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE: begin
                state_d = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (cu_done_i) begin
                    state_d = c_ADVANCE;
                end
            end
            c_ADVANCE: begin
                if (w_abort_seen || (w_last_k && w_last_n)) begin
                    state_d = c_FINISH;
                end else if (w_last_k) begin
                    k_d     = '0;
                    n_d     = n_q + c_ONE;
                    row_d   = row_q + c_ROW_STRIDE;
                    state_d = c_FETCH_W;
                end else begin
                    k_d     = k_q + c_ONE;
                    state_d = c_FETCH_W;
                end
            end
            c_FINISH: begin
                abort_d = 1'b0;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= c_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            k_tiles_q <= '0;
            n_tiles_q <= '0;
            row_q     <= '0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            k_tiles_q <= k_tiles_d;
            n_tiles_q <= n_tiles_d;
            row_q     <= row_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
        end
    end

    // Status strobes are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wfifo_req_q <= 1'b0;
            cu_instr_q  <= 1'b0;
            job_done_q  <= 1'b0;
            addr_q      <= '0;
            accum_q     <= 1'b0;
        end else begin
            job_ready_q <= (state_d == c_IDLE);
            busy_q      <= (state_d != c_IDLE);
            wfifo_req_q <= (state_d == c_FETCH_W);
            cu_instr_q  <= (state_d == c_ISSUE);
            job_done_q  <= (state_d == c_FINISH);
            if (w_issue) begin
                addr_q  <= row_q;
                accum_q <= (k_q != '0);
            end
        end
    end

    assign job_ready_o         = job_ready_q;
    assign busy_o              = busy_q;
    assign wfifo_req_o         = wfifo_req_q;
    assign cu_instruction_o    = cu_instr_q;
    assign job_done_o          = job_done_q;
    assign cu_acc_start_addr_o = addr_q;
    assign acc_accumulate_o    = accum_q;
    assign tile_k_idx_o        = k_q;
    assign tile_n_idx_o        = n_q;
    assign err_o               = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_scheduler
// Function : Scoreboard bench for tile_scheduler with weight-FIFO and
//            control-unit responders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       job_valid_i;
    logic       job_ready_o;
    logic [7:0] job_k_tiles_i;
    logic [7:0] job_n_tiles_i;
    logic [6:0] job_acc_base_i;
    logic       abort_i;
    logic       wfifo_req_o;
    logic       wfifo_tile_rdy_i;
    logic       cu_instruction_o;
    logic       cu_done_i;
    logic [6:0] cu_acc_start_addr_o;
    logic       acc_accumulate_o;
    logic [7:0] tile_k_idx_o;
    logic [7:0] tile_n_idx_o;
    logic       busy_o;
    logic       job_done_o;
    logic       err_o;

    logic cu_done_auto;
    logic cu_done_man;
    assign cu_done_i = cu_done_auto | cu_done_man;

    tile_scheduler dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .job_valid_i         (job_valid_i),
        .job_ready_o         (job_ready_o),
        .job_k_tiles_i       (job_k_tiles_i),
        .job_n_tiles_i       (job_n_tiles_i),
        .job_acc_base_i      (job_acc_base_i),
        .abort_i             (abort_i),
        .wfifo_req_o         (wfifo_req_o),
        .wfifo_tile_rdy_i    (wfifo_tile_rdy_i),
        .cu_instruction_o    (cu_instruction_o),
        .cu_done_i           (cu_done_i),
        .cu_acc_start_addr_o (cu_acc_start_addr_o),
        .acc_accumulate_o    (acc_accumulate_o),
        .tile_k_idx_o        (tile_k_idx_o),
        .tile_n_idx_o        (tile_n_idx_o),
        .busy_o              (busy_o),
        .job_done_o          (job_done_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic       acc;
        logic [7:0] k;
        logic [7:0] n;
    } instr_t;

    instr_t exp_instr[$];
    logic   exp_err[$];
    int     total = 0;
    int     bad = 0;
    int     wf_lat = 2;
    int     cu_lat = 3;
    bit     cu_auto = 1'b1;
    int     cyc = 0;
    int     last_cudone_cyc = 0;
    int     wreq_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_i(input logic [6:0] a, input logic acc, input logic [7:0] k, input logic [7:0] n);
        instr_t e;
        e.addr = a; e.acc = acc; e.k = k; e.n = n;
        exp_instr.push_back(e);
    endtask

    // Weight FIFO: raises tile-ready for one cycle wf_lat cycles into a request.
    initial begin : wfifo_model
        int wait_c;
        wait_c = 0;
        wfifo_tile_rdy_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wfifo_tile_rdy_i) begin
                wfifo_tile_rdy_i = 1'b0;
                wait_c = 0;
            end else if (wfifo_req_o) begin
                wait_c++;
                if (wait_c >= wf_lat) wfifo_tile_rdy_i = 1'b1;
            end else begin
                wait_c = 0;
            end
        end
    end

    // Control unit: one done pulse cu_lat cycles after each instruction.
    initial begin : cu_model
        int cnt;
        cnt = -1;
        cu_done_auto = 1'b0;
        forever begin
            @(posedge clk); #1;
            cu_done_auto = 1'b0;
            if (!cu_auto) begin
                cnt = -1;
            end else if (cu_instruction_o) begin
                cnt = cu_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    cu_done_auto = 1'b1;
                    cnt = -1;
                end
            end
        end
    end

    initial begin : monitor
        instr_t e;
        logic   ee;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (wfifo_req_o) wreq_cycles++;
                if (cu_done_i) last_cudone_cyc = cyc;
                if (cu_instruction_o) begin
                    if (exp_instr.size() == 0) begin
                        chk("instr_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_instr.pop_front();
                        chk("instr_addr", 32'(cu_acc_start_addr_o), 32'(e.addr));
                        chk("instr_acc", 32'(acc_accumulate_o), 32'(e.acc));
                        chk("instr_k", 32'(tile_k_idx_o), 32'(e.k));
                        chk("instr_n", 32'(tile_n_idx_o), 32'(e.n));
                    end
                end
                if (job_done_o) begin
                    if (exp_err.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        ee = exp_err.pop_front();
                        chk("done_err", 32'(err_o), 32'(ee));
                    end
                end
            end
        end
    end

    task automatic submit(input logic [7:0] k, input logic [7:0] n, input logic [6:0] b);
        int t;
        t = 0;
        while (!job_ready_o && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("submit_ready", 32'(job_ready_o), 32'd1);
        job_k_tiles_i  = k;
        job_n_tiles_i  = n;
        job_acc_base_i = b;
        job_valid_i    = 1'b1;
        @(posedge clk); #1;
        job_valid_i    = 1'b0;
        job_k_tiles_i  = 8'd7;
        job_n_tiles_i  = 8'd7;
        job_acc_base_i = 7'h55;
    endtask

    task automatic wait_done(output int done_cyc);
        int t;
        t = 0;
        done_cyc = 0;
        while (t < 600) begin
            @(negedge clk);
            if (job_done_o) begin
                done_cyc = cyc;
                break;
            end
            t++;
        end
        if (t >= 600) chk("done_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_instr(input int count);
        int t;
        int seen;
        t = 0;
        seen = 0;
        while (seen < count && t < 300) begin
            @(negedge clk);
            if (cu_instruction_o) seen++;
            t++;
        end
        if (seen < count) chk("instr_timeout", 32'(seen), 32'(count));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int dc;
        int wr0;
        rst_i          = 1'b1;
        job_valid_i    = 1'b0;
        job_k_tiles_i  = '0;
        job_n_tiles_i  = '0;
        job_acc_base_i = '0;
        abort_i        = 1'b0;
        cu_done_man    = 1'b0;
        #1;
        chk("rst_ready", 32'(job_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", {busy_o, wfifo_req_o, cu_instruction_o, job_done_o, err_o,
                             acc_accumulate_o, cu_acc_start_addr_o, tile_k_idx_o, tile_n_idx_o}, 32'd0);
        chk("idle_ready", 32'(job_ready_o), 32'd1);

        // Async reset while waiting on the control unit.
        cu_auto = 1'b0;
        wf_lat  = 1;
        push_i(7'h00, 1'b0, 8'd0, 8'd0);
        submit(8'd2, 8'd2, 7'h00);
        chk("busy_after_accept", 32'(job_ready_o), 32'd0);
        wait_instr(1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        chk("midrst_ready", 32'(job_ready_o), 32'd1);
        chk("midrst_outputs", {busy_o, wfifo_req_o, cu_instruction_o, job_done_o, err_o,
                               acc_accumulate_o, cu_acc_start_addr_o, tile_k_idx_o, tile_n_idx_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk); #1 cu_done_man = 1'b1;
        @(posedge clk); #1 cu_done_man = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_idle_busy", 32'(busy_o), 32'd0);
        chk("midrst_q_empty", 32'(exp_instr.size()), 32'd0);
        cu_auto = 1'b1;

        // K=1 N=1: single tile, done two cycles after the CU done pulse.
        wf_lat = 2;
        cu_lat = 3;
        push_i(7'h00, 1'b0, 8'd0, 8'd0);
        exp_err.push_back(1'b0);
        submit(8'd1, 8'd1, 7'h00);
        wait_done(dc);
        chk("k1n1_done_latency", 32'(dc - last_cudone_cyc), 32'd2);
        chk("k1n1_q_empty", 32'(exp_instr.size() + exp_err.size()), 32'd0);

        // K=3 N=2 base 0x10.
        push_i(7'h10, 1'b0, 8'd0, 8'd0);
        push_i(7'h10, 1'b1, 8'd1, 8'd0);
        push_i(7'h10, 1'b1, 8'd2, 8'd0);
        push_i(7'h30, 1'b0, 8'd0, 8'd1);
        push_i(7'h30, 1'b1, 8'd1, 8'd1);
        push_i(7'h30, 1'b1, 8'd2, 8'd1);
        exp_err.push_back(1'b0);
        submit(8'd3, 8'd2, 7'h10);
        wait_done(dc);
        chk("k3n2_q_empty", 32'(exp_instr.size() + exp_err.size()), 32'd0);

        // K=1 N=4 base 0x60: address wraps silently.
        wf_lat = 1;
        push_i(7'h60, 1'b0, 8'd0, 8'd0);
        push_i(7'h00, 1'b0, 8'd0, 8'd1);
        push_i(7'h20, 1'b0, 8'd0, 8'd2);
        push_i(7'h40, 1'b0, 8'd0, 8'd3);
        exp_err.push_back(1'b0);
        submit(8'd1, 8'd4, 7'h60);
        wait_done(dc);
        chk("k1n4_q_empty", 32'(exp_instr.size() + exp_err.size()), 32'd0);
        chk("k1n4_err", 32'(err_o), 32'd0);

        // K=0 N=5: immediate finish with error, then cleared by next job.
        wr0 = wreq_cycles;
        exp_err.push_back(1'b1);
        submit(8'd0, 8'd5, 7'h08);
        wait_done(dc);
        chk("k0_no_wreq", 32'(wreq_cycles - wr0), 32'd0);
        chk("k0_err_sticky", 32'(err_o), 32'd1);
        push_i(7'h05, 1'b0, 8'd0, 8'd0);
        exp_err.push_back(1'b0);
        submit(8'd1, 8'd1, 7'h05);
        chk("err_cleared_on_accept", 32'(err_o), 32'd0);
        wait_done(dc);
        chk("k0_q_empty", 32'(exp_instr.size() + exp_err.size()), 32'd0);

        // K=4 N=1: abort during second WAIT_DONE.
        cu_lat = 6;
        push_i(7'h00, 1'b0, 8'd0, 8'd0);
        push_i(7'h00, 1'b1, 8'd1, 8'd0);
        exp_err.push_back(1'b1);
        submit(8'd4, 8'd1, 7'h00);
        wait_instr(2);
        @(posedge clk); #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
        wait_done(dc);
        chk("abort_wait_q_empty", 32'(exp_instr.size() + exp_err.size()), 32'd0);
        chk("abort_wait_err", 32'(err_o), 32'd1);

        // Abort while fetching the first weight tile.
        wf_lat = 10;
        exp_err.push_back(1'b1);
        submit(8'd2, 8'd2, 7'h00);
        begin
            int t;
            t = 0;
            while (!wfifo_req_o && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        chk("fetch_req_high", 32'(wfifo_req_o), 32'd1);
        @(posedge clk); #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
        chk("fetch_abort_req_drop", 32'(wfifo_req_o), 32'd0);
        chk("fetch_abort_done", 32'(job_done_o), 32'd1);
        @(posedge clk); #1;
        chk("fetch_abort_idle", {30'd0, job_ready_o, busy_o}, 32'd2);
        chk("fetch_abort_err", 32'(err_o), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("final_q_empty", 32'(exp_instr.size() + exp_err.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
